// File: rtl/usb_frame_receiver_pkg.sv
// Shared definitions for the USB frame receiver: word/sample widths,
// default frame length and the frame state encoding.
package usb_frame_receiver_pkg;

  localparam int FRAME_LEN_DEFAULT = 1024;
  localparam int SAMPLE_W          = 16;
  localparam int WORD_W            = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/usb_frame_receiver_frame_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one read port
// with a registered output (1-cycle latency). The read register only updates
// when re_i is high, so the read side can stall without losing a word.
// No reset, so it maps onto block RAM.
module frame_ram
  import usb_frame_receiver_pkg::*;
#(
  parameter int DEPTH  = FRAME_LEN_DEFAULT,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Store the host word at the write address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; holds its value while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_frame_receiver.sv
// USB frame receiver: collects FRAME_LEN host words into a frame buffer,
// then streams them to the FFT in address order with a valid/ready
// handshake. The read side is a two-stage pipeline (RAM read register,
// then output holding register) so samples flow one per cycle while
// fft_ready is high and hold steady while it is low.
module usb_frame_receiver
  import usb_frame_receiver_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int ADDR_W    = 10
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [WORD_W-1:0]   data_in,
  input  logic                data_in_valid,
  output logic                data_in_ready,
  input  logic                fft_ready,
  output logic [SAMPLE_W-1:0] data_out_re,
  output logic [SAMPLE_W-1:0] data_out_im,
  output logic                data_out_valid,
  output logic                frame_start,
  output logic                frame_done
);

  if (FRAME_LEN < 4 || (1 << ADDR_W) != FRAME_LEN) begin : g_cfg_check
    $error("usb_frame_receiver: FRAME_LEN must be a power of two >= 4 and ADDR_W = log2(FRAME_LEN)");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   out_cnt_q;
  logic                in_rdy_q;
  logic                done_q;
  logic                rd_more_q;
  logic                ram_vld_q;
  logic                ram_first_q;
  logic                out_vld_q;
  logic                out_first_q;
  logic [WORD_W-1:0]   out_word_q;
  logic [WORD_W-1:0]   ram_rdata;

  logic in_xfer;
  logic wr_last;
  logic out_xfer;
  logic out_last;
  logic ram_adv;
  logic rd_issue;
  logic ram_vld_d;

  // Input ready is a registered flag, forced low while reset is held so the
  // host sees no acceptance during reset but sees it immediately after.
  assign data_in_ready = in_rdy_q & ~reset;
  assign in_xfer       = data_in_valid & data_in_ready;
  assign wr_last       = in_xfer & (state_q == ST_FILL) & (wr_addr_q == LAST_ADDR);

  assign out_xfer = out_vld_q & fft_ready;
  assign out_last = out_xfer & (out_cnt_q == LAST_ADDR);

  // The RAM word moves into the output register when that register is empty
  // or being emptied this cycle.
  assign ram_adv   = ram_vld_q & (~out_vld_q | fft_ready);
  // Address 0 is read on the final fill write (it was written long before),
  // which places sample 0 on the outputs two cycles after that write.
  assign rd_issue  = wr_last | (rd_more_q & (~ram_vld_q | ram_adv));
  assign ram_vld_d = rd_issue | (ram_vld_q & ~ram_adv);

  frame_ram #(
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W)
  ) u_frame_ram (
    .clk_i   (CLK),
    .we_i    (in_xfer),
    .waddr_i (wr_addr_q),
    .wdata_i (data_in),
    .re_i    (rd_issue),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  // Frame state machine with write address, input ready and done pulse.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      in_rdy_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_xfer) begin
        wr_addr_q <= wr_addr_q + ONE;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (in_xfer) begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (wr_last) begin
            state_q  <= ST_DRAIN;
            in_rdy_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (out_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          in_rdy_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read address sequencing and RAM-stage occupancy.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_addr_q   <= '0;
      rd_more_q   <= 1'b0;
      ram_vld_q   <= 1'b0;
      ram_first_q <= 1'b0;
    end else begin
      ram_vld_q <= ram_vld_d;
      if (rd_issue) begin
        rd_addr_q   <= rd_addr_q + ONE;
        rd_more_q   <= (rd_addr_q != LAST_ADDR);
        ram_first_q <= (rd_addr_q == '0);
      end
    end
  end

  // Output holding register: loads from the RAM stage, holds while stalled.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_vld_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_word_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      if (out_xfer) begin
        out_cnt_q <= out_cnt_q + ONE;
      end
      if (ram_adv) begin
        out_word_q  <= ram_rdata;
        out_vld_q   <= 1'b1;
        out_first_q <= ram_first_q;
      end else if (fft_ready) begin
        out_vld_q   <= 1'b0;
        out_first_q <= 1'b0;
      end
    end
  end

  assign data_out_re    = out_word_q[WORD_W-1:SAMPLE_W];
  assign data_out_im    = out_word_q[SAMPLE_W-1:0];
  assign data_out_valid = out_vld_q;
  assign frame_start    = out_first_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_usb_frame_receiver.sv
// Bench for usb_frame_receiver: frame-level model (accepted words queue,
// expected output queue, cycle bookkeeping) checked every cycle, plus
// literal expectations per scenario.
module tb_usb_frame_receiver;

  localparam int FRAME_LEN = 1024;
  localparam int ADDR_W    = 10;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic        fft_ready;
  logic [15:0] data_out_re;
  logic [15:0] data_out_im;
  logic        data_out_valid;
  logic        frame_start;
  logic        frame_done;

  usb_frame_receiver #(
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .fft_ready      (fft_ready),
    .data_out_re    (data_out_re),
    .data_out_im    (data_out_im),
    .data_out_valid (data_out_valid),
    .frame_start    (frame_start),
    .frame_done     (frame_done)
  );

  initial forever #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [31:0] m_acc[$];
  logic [31:0] m_exp[$];
  int  m_idx        = 0;
  bit  m_drain      = 0;
  bit  m_busy       = 0;
  int  m_present_at = 0;
  int  m_done_at    = -1;
  int  cyc          = 0;

  logic [31:0] first_word = '0;
  logic [31:0] last_word  = '0;
  int  out_count       = 0;
  int  done_pulses     = 0;
  int  last_in_cyc     = 0;
  int  first_valid_cyc = 0;
  bit  first_seen      = 0;

  bit          prev_stall = 0;
  logic [31:0] prev_word  = '0;
  logic        prev_start = 1'b0;
  bit          exp_ready, exp_done, exp_valid;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (reset) begin
        chk("rst_in_ready",  32'(data_in_ready),  32'd0);
        chk("rst_out_valid", 32'(data_out_valid), 32'd0);
        chk("rst_start",     32'(frame_start),    32'd0);
        chk("rst_done",      32'(frame_done),     32'd0);
        chk("rst_data",      {data_out_re, data_out_im}, 32'd0);
        m_acc.delete();
        m_exp.delete();
        m_idx      = 0;
        m_drain    = 0;
        m_busy     = 0;
        m_done_at  = -1;
        prev_stall = 0;
      end else begin
        exp_ready = !m_busy;
        chk("in_ready", 32'(data_in_ready), 32'(exp_ready));
        exp_done = (cyc == m_done_at);
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        if (frame_done) done_pulses++;
        if (exp_done) m_busy = 0;

        exp_valid = m_drain && (cyc >= m_present_at);
        chk("out_valid", 32'(data_out_valid), 32'(exp_valid));
        if (prev_stall) begin
          chk("hold_data", {data_out_re, data_out_im}, prev_word);
          chk("hold_flags", {30'd0, data_out_valid, frame_start}, {30'd0, 1'b1, prev_start});
        end
        if (exp_valid && data_out_valid) begin
          chk("out_data", {data_out_re, data_out_im}, m_exp[m_idx]);
          chk("frame_start", 32'(frame_start), 32'(m_idx == 0));
          if (m_idx == 0 && !first_seen) begin
            first_seen      = 1;
            first_valid_cyc = cyc;
            first_word      = {data_out_re, data_out_im};
          end
          if (fft_ready) begin
            last_word = {data_out_re, data_out_im};
            m_idx++;
            out_count++;
            if (m_idx == FRAME_LEN) begin
              m_drain   = 0;
              m_done_at = cyc + 1;
            end
          end
        end else begin
          chk("start_idle", 32'(frame_start), 32'd0);
        end
        prev_stall = data_out_valid && !fft_ready;
        prev_word  = {data_out_re, data_out_im};
        prev_start = frame_start;

        if (exp_ready && data_in_valid) begin
          m_acc.push_back(data_in);
          last_in_cyc = cyc;
          if (m_acc.size() == FRAME_LEN) begin
            m_exp        = m_acc;
            m_acc.delete();
            m_drain      = 1;
            m_idx        = 0;
            m_present_at = cyc + 2;
            m_busy       = 1;
            first_seen   = 0;
          end
        end
      end
    end
  end

  // ---------------- FFT-side ready driver ----------------
  int fmode = 0;
  int pcnt  = 0;
  initial begin
    fft_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      pcnt++;
      fft_ready = (fmode == 0) || ((pcnt % 4) == 3);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] wgen(input int t, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    case (t)
      1:       wgen = {kk, ~kk};
      2:       wgen = {16'h5A00 + kk, 16'h8000 ^ kk};
      3:       wgen = {16'h7FFF - kk, kk};
      4:       wgen = {kk, 16'h1234};
      5:       wgen = {16'h2000 + kk, kk};
      6:       wgen = {16'hDEAD, kk};
      7:       wgen = {kk ^ 16'h00F0, 16'hBEEF};
      default: wgen = {16'h4000 + kk, kk};
    endcase
  endfunction

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    data_in       = w;
    data_in_valid = 1'b1;
    @(negedge CLK);
    while (!data_in_ready && n < 4 * FRAME_LEN) begin
      @(negedge CLK);
      n++;
    end
    if (!data_in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=accept word=%0h", w);
    end
    @(posedge CLK);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (frame_done !== 1'b1 && n < 8 * FRAME_LEN);
    chk("done_seen", 32'(frame_done), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  int d0, o0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #2 reset = 1'b0;
    @(posedge CLK);
    #1;

    // Single frame, both sides always ready.
    d0 = done_pulses; o0 = out_count;
    for (int k = 0; k < FRAME_LEN; k++) send_word(wgen(1, k));
    wait_done();
    chk("t1_first_word", first_word, 32'h0000FFFF);
    chk("t1_last_word",  last_word,  32'h03FFFC00);
    chk("t1_latency",    32'(first_valid_cyc - last_in_cyc), 32'd2);
    chk("t1_samples",    32'(out_count - o0), 32'd1024);
    chk("t1_done_cnt",   32'(done_pulses - d0), 32'd1);

    // Random input gaps during fill.
    d0 = done_pulses; o0 = out_count;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send_word(wgen(2, k));
    end
    wait_done();
    chk("t2_first_word", first_word, 32'h5A008000);
    chk("t2_last_word",  last_word,  32'h5DFF83FF);
    chk("t2_samples",    32'(out_count - o0), 32'd1024);
    chk("t2_done_cnt",   32'(done_pulses - d0), 32'd1);

    // FFT stalls three cycles of every four.
    fmode = 1;
    d0 = done_pulses; o0 = out_count;
    for (int k = 0; k < FRAME_LEN; k++) send_word(wgen(3, k));
    wait_done();
    fmode = 0;
    chk("t3_first_word", first_word, 32'h7FFF0000);
    chk("t3_last_word",  last_word,  32'h7C0003FF);
    chk("t3_samples",    32'(out_count - o0), 32'd1024);
    chk("t3_done_cnt",   32'(done_pulses - d0), 32'd1);

    // Host holds a word through drain; it opens the next frame.
    d0 = done_pulses; o0 = out_count;
    for (int k = 0; k < FRAME_LEN; k++) send_word(wgen(4, k));
    send_word(32'hCAFE0001);
    for (int k = 1; k < FRAME_LEN; k++) send_word(wgen(5, k));
    wait_done();
    chk("t4_first_word", first_word, 32'hCAFE0001);
    chk("t4_last_word",  last_word,  32'h23FF03FF);
    chk("t4_samples",    32'(out_count - o0), 32'd2048);
    chk("t4_done_cnt",   32'(done_pulses - d0), 32'd2);

    // Reset after 500 input words, then a full frame.
    for (int k = 0; k < 500; k++) send_word(wgen(6, k));
    #1 reset = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #2 reset = 1'b0;
    d0 = done_pulses; o0 = out_count;
    for (int k = 0; k < FRAME_LEN; k++) send_word(wgen(7, k));
    wait_done();
    chk("t5_first_word", first_word, 32'h00F0BEEF);
    chk("t5_last_word",  last_word,  32'h030FBEEF);
    chk("t5_samples",    32'(out_count - o0), 32'd1024);
    chk("t5_done_cnt",   32'(done_pulses - d0), 32'd1);

    // Reset during drain at output sample 300, then a full frame.
    d0 = done_pulses;
    for (int k = 0; k < FRAME_LEN; k++) send_word(wgen(8, k));
    for (int n = 0; n < 4 * FRAME_LEN && m_idx < 300; n++) @(posedge CLK);
    chk("t6_reached_300", 32'(m_idx >= 300), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(data_out_valid), 32'd0);
    chk("t6_async_start", 32'(frame_start), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2 reset = 1'b0;
    o0 = out_count;
    for (int k = 0; k < FRAME_LEN; k++) send_word(wgen(1, k));
    wait_done();
    chk("t6_first_word", first_word, 32'h0000FFFF);
    chk("t6_samples",    32'(out_count - o0), 32'd1024);
    chk("t6_done_cnt",   32'(done_pulses - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_frame_receiver.md
USB_FRAME_RECEIVER -- requirements
Module: usb_frame_receiver

Interface
REQ-001 Parameter FRAME_LEN, default 1024, samples per frame (power of two, 4..4096).
REQ-002 Parameter ADDR_W, default 10, frame address width; SHALL equal log2(FRAME_LEN).
REQ-003 Port CLK  input  1  single clock; all logic rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port data_in  input  32  host word: [31:16] = real, [15:0] = imaginary, two's complement.
REQ-006 Port data_in_valid  input  1  host word present.
REQ-007 Port data_in_ready  output  1  block accepts the word this cycle.
REQ-008 Port fft_ready  input  1  FFT accepts the presented sample this cycle.
REQ-009 Port data_out_re  output  16  real part of the presented sample.
REQ-010 Port data_out_im  output  16  imaginary part of the presented sample.
REQ-011 Port data_out_valid  output  1  sample presented.
REQ-012 Port frame_start  output  1  high with sample 0 of a frame while data_out_valid is high.
REQ-013 Port frame_done  output  1  one-cycle pulse after the last sample of a frame is accepted.

Function
REQ-014 Input handshake: a word transfers on a cycle where data_in_valid and data_in_ready are both high; no other input cycle has any effect.
REQ-015 Output handshake: a sample transfers on a cycle where data_out_valid and fft_ready are both high.
REQ-016 While data_out_valid is high and fft_ready is low, data_out_re, data_out_im, data_out_valid and frame_start SHALL hold.
REQ-017 States: IDLE, FILL, DRAIN, DONE.
REQ-018 IDLE: data_in_ready = 1 and the write address is 0.
REQ-019 IDLE -> FILL on the first input transfer; the word is stored at address 0.
REQ-020 FILL: data_in_ready = 1; each transfer writes address n, then n+1.
REQ-021 FILL -> DRAIN on the transfer that writes address FRAME_LEN-1; the write address wraps to 0.
REQ-022 DRAIN: data_in_ready = 0; input words are back-pressured, never dropped or overwritten.
REQ-023 Samples SHALL be presented in address order 0..FRAME_LEN-1, bit-exact to the stored words, with no packing, sign extension or scaling.
REQ-024 Sample 0 is presented (data_out_valid high) exactly 2 cycles after the final FILL transfer.
REQ-025 With fft_ready held high, samples stream one per cycle with no bubbles.
REQ-026 DRAIN -> DONE on the transfer of sample FRAME_LEN-1; data_out_valid deasserts the following cycle unless another transfer occurs.
REQ-027 DONE lasts one cycle, asserts frame_done and returns to IDLE.
REQ-028 In IDLE, data_in_ready is high the cycle after DONE, so back-to-back frames lose only the DRAIN and DONE cycles.
REQ-029 A frame of FRAME_LEN = 1 word is not supported; FRAME_LEN >= 4 is enforced by a static assertion.

Reset
REQ-030 Assertion of reset SHALL, asynchronously, set the state to IDLE and clear both address counters to 0.
REQ-031 Output reset values: data_in_ready = 0 while reset is high, data_out_valid = 0, frame_start = 0, frame_done = 0, data_out_re = 0, data_out_im = 0.
REQ-032 Reset mid-FILL or mid-DRAIN discards the partial frame; RAM contents are not cleared and never reach the outputs.
REQ-033 After reset is released, the first cycle is IDLE with data_in_ready = 1.

Structure
REQ-034 Shared package holds FRAME_LEN_DEFAULT = 1024, SAMPLE_W = 16, WORD_W = 32 and the state encoding type.
REQ-035 One sub-module, frame_ram: simple dual-port, 32 x FRAME_LEN, synchronous write, registered read with 1-cycle latency, inferable as block RAM, no reset.
REQ-036 The output skid/holding register and state machine live in usb_frame_receiver.

Verification
REQ-037 Single frame, both sides always ready, word k = {k, ~k}: 1024 samples out in order; first sample 2 cycles after the last input; frame_start only on re = 0; one frame_done pulse.
REQ-038 Random data_in_valid gaps (50%) in FILL: the output frame is identical to the accepted sequence; no duplicates or drops.
REQ-039 fft_ready toggles with a 3-low/1-high pattern in DRAIN: outputs hold stable while stalled; all 1024 samples are delivered; the final count matches.
REQ-040 Host keeps data_in_valid high through DRAIN: data_in_ready = 0 until IDLE; the next frame begins with the held word at address 0.
REQ-041 Reset asserted at input sample 500, then a full frame is sent: no output from the partial frame; the new frame is output correctly.
REQ-042 Reset asserted during DRAIN at output sample 300: data_out_valid = 0 immediately (asynchronously); no frame_done pulse; the next frame restarts at sample 0.
